// File: rtl/framebuffer_write_scheduler_pkg.sv
// Shared display definitions: pixel colour type, default panel geometry and
// scheduler state encoding.
package framebuffer_write_scheduler_pkg;

  typedef logic [15:0] ILI9341_color_t;

  localparam int DEF_DISPLAY_WIDTH  = 240;
  localparam int DEF_DISPLAY_HEIGHT = 320;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/color_compress.sv
// RGB565 to RGB332 colour reduction: keeps the top bits of each channel.
module color_compress
  import framebuffer_write_scheduler_pkg::*;
(
  input  ILI9341_color_t c,
  output logic [7:0]     rgb332
);

  logic unused_low_bits;

  assign rgb332          = {c[15:13], c[10:8], c[4:3]};
  assign unused_low_bits = ^{c[12:11], c[7:5], c[2:0]};

endmodule

// File: rtl/framebuffer_write_scheduler.sv
// Arbitrates two pixel-write requesters and a full-screen clear onto a single
// RGB332 framebuffer write port, with one cycle of write latency.
module framebuffer_write_scheduler
  import framebuffer_write_scheduler_pkg::*;
#(
  parameter  int DISPLAY_WIDTH  = DEF_DISPLAY_WIDTH,
  parameter  int DISPLAY_HEIGHT = DEF_DISPLAY_HEIGHT,
  localparam int FB_DEPTH       = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  localparam int FB_AW          = $clog2(FB_DEPTH)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [15:0]      a_x,
  input  logic [15:0]      a_y,
  input  ILI9341_color_t   a_color,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [15:0]      b_x,
  input  logic [15:0]      b_y,
  input  ILI9341_color_t   b_color,
  input  logic             clear_start,
  input  ILI9341_color_t   clear_color,
  output logic             clear_busy,
  output logic             clear_done,
  output logic             fb_wr_ena,
  output logic [FB_AW-1:0] fb_wr_addr,
  output logic [7:0]       fb_wr_data,
  output logic             oob_drop
);

  localparam logic [FB_AW:0] WIDTH_C = (FB_AW+1)'(DISPLAY_WIDTH);
  localparam logic [FB_AW:0] DEPTH_C = (FB_AW+1)'(FB_DEPTH);
  localparam logic [16:0]    X_LIM   = 17'(DISPLAY_WIDTH);
  localparam logic [16:0]    Y_LIM   = 17'(DISPLAY_HEIGHT);

  logic [0:0]       state;
  logic             prefer_b;
  logic [FB_AW:0]   sweep_cnt;
  logic [7:0]       clr_data;

  logic             a_rdy, b_rdy;
  logic             acc_a, acc_b, accept;
  logic             clear_go;
  logic [15:0]      sel_x, sel_y;
  ILI9341_color_t   sel_color;
  logic [7:0]       sel_rgb;
  logic             oob_req;
  logic [FB_AW:0]   addr_full;
  logic             unused_addr_msb;

  logic             wr_vld_p1;
  logic [FB_AW-1:0] wr_addr_p1;
  logic [7:0]       wr_data_p1;
  logic             oob_p1;
  logic             busy_p1;
  logic             done_p1;

  // Grant: clear wins, otherwise alternate when both requesters compete
  always_comb begin
    a_rdy = 1'b0;
    b_rdy = 1'b0;
    if (!rst && state == ST_IDLE && !clear_start) begin
      if (a_valid && (!b_valid || !prefer_b)) a_rdy = 1'b1;
      else if (b_valid)                       b_rdy = 1'b1;
    end
  end

  assign a_ready  = a_rdy;
  assign b_ready  = b_rdy;
  assign acc_a    = a_valid && a_rdy;
  assign acc_b    = b_valid && b_rdy;
  assign accept   = acc_a || acc_b;
  assign clear_go = state == ST_IDLE && clear_start;

  assign sel_x     = acc_b ? b_x : a_x;
  assign sel_y     = acc_b ? b_y : a_y;
  assign sel_color = clear_go ? clear_color : (acc_b ? b_color : a_color);

  color_compress u_color_compress (
    .c      (sel_color),
    .rgb332 (sel_rgb)
  );

  // Coordinates are checked at full width before the address is narrowed
  assign oob_req         = ({1'b0, sel_x} >= X_LIM) || ({1'b0, sel_y} >= Y_LIM);
  assign addr_full       = (FB_AW+1)'(sel_y) * WIDTH_C + (FB_AW+1)'(sel_x);
  assign unused_addr_msb = addr_full[FB_AW];

  // p1: registered write port, status pulses and control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      prefer_b   <= 1'b0;
      sweep_cnt  <= '0;
      clr_data   <= '0;
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
      oob_p1     <= 1'b0;
      busy_p1    <= 1'b0;
      done_p1    <= 1'b0;
    end else begin
      wr_vld_p1 <= 1'b0;
      oob_p1    <= 1'b0;
      busy_p1   <= 1'b0;
      done_p1   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clear_start) begin
            state      <= ST_CLEAR;
            clr_data   <= sel_rgb;
            sweep_cnt  <= (FB_AW+1)'(1);
            wr_vld_p1  <= 1'b1;
            wr_addr_p1 <= '0;
            wr_data_p1 <= sel_rgb;
            busy_p1    <= 1'b1;
          end else if (accept) begin
            prefer_b <= acc_a;
            if (oob_req) begin
              oob_p1 <= 1'b1;
            end else begin
              wr_vld_p1  <= 1'b1;
              wr_addr_p1 <= addr_full[FB_AW-1:0];
              wr_data_p1 <= sel_rgb;
            end
          end
        end
        ST_CLEAR: begin
          // The sweep stays in CLEAR through its last write so readies stay low
          if (sweep_cnt == DEPTH_C) begin
            state     <= ST_IDLE;
            sweep_cnt <= '0;
            done_p1   <= 1'b1;
          end else begin
            wr_vld_p1  <= 1'b1;
            wr_addr_p1 <= sweep_cnt[FB_AW-1:0];
            wr_data_p1 <= clr_data;
            busy_p1    <= 1'b1;
            sweep_cnt  <= sweep_cnt + (FB_AW+1)'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fb_wr_ena  = wr_vld_p1;
  assign fb_wr_addr = wr_addr_p1;
  assign fb_wr_data = wr_data_p1;
  assign oob_drop   = oob_p1;
  assign clear_busy = busy_p1;
  assign clear_done = done_p1;

endmodule
